dual_port_ram_access_ctrl: RTL

- Upstream request controller for the 8-deep x 8-bit dual-port RAM; owns both RAM ports from two requesters (A, B) using valid/ready handshakes.
- Resolves same-address collisions, enforces write-before-read ordering, and prevents B starvation via an aging counter.
- Drives registered en/we/addr/data to the RAM and returns read data with a matching rvalid.

---
 rtl/dual_port_ram_access_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/dual_port_ram_access_ctrl.sv
// rtl/dual_port_ram_access_ctrl.sv - two-requester access controller for an 8x8 dual-port RAM
// Optional DUAL_PORT_COLLISION_CNT_EN adds a saturating collision counter on collision_cnt_o.
module dual_port_ram_access_ctrl #(
    parameter int ADDR_W    = 3,
    parameter int DATA_W    = 8,
    parameter int MAX_STALL = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_a_i,
    input  logic              req_valid_b_i,
    output logic              req_ready_a_o,
    output logic              req_ready_b_o,
    input  logic              req_we_a_i,
    input  logic              req_we_b_i,
    input  logic [ADDR_W-1:0] req_addr_a_i,
    input  logic [ADDR_W-1:0] req_addr_b_i,
    input  logic [DATA_W-1:0] req_wdata_a_i,
    input  logic [DATA_W-1:0] req_wdata_b_i,
    output logic              ram_en_a_o,
    output logic              ram_en_b_o,
    output logic              ram_we_a_o,
    output logic              ram_we_b_o,
    output logic [ADDR_W-1:0] ram_addr_a_o,
    output logic [ADDR_W-1:0] ram_addr_b_o,
    output logic [DATA_W-1:0] ram_data_a_o,
    output logic [DATA_W-1:0] ram_data_b_o,
    input  logic [DATA_W-1:0] ram_rdata_a_i,
    input  logic [DATA_W-1:0] ram_rdata_b_i,
    output logic              rd_valid_a_o,
    output logic              rd_valid_b_o,
    output logic [DATA_W-1:0] rd_data_a_o,
    output logic [DATA_W-1:0] rd_data_b_o,
    output logic [7:0]        collision_cnt_o
);

    typedef enum logic {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } pri_t;

    localparam logic [3:0] STALL_LIM = 4'(MAX_STALL);

    pri_t       state, state_n;
    logic [3:0] stall_cnt, stall_cnt_n;
    logic       collision;
    logic       stall_a, stall_b;
    logic       acc_a, acc_b;
    logic       rd_pend_a, rd_pend_b;

    assign collision = req_valid_a_i && req_valid_b_i
                    && (req_addr_a_i == req_addr_b_i)
                    && (req_we_a_i || req_we_b_i);

    // A write always beats a read to the same address so the read sees new data.
    always_comb begin
        stall_a = 1'b0;
        stall_b = 1'b0;
        if (collision) begin
            if (req_we_a_i && req_we_b_i) begin
                if (state == PRI_A) stall_b = 1'b1;
                else                stall_a = 1'b1;
            end else if (req_we_a_i) begin
                stall_b = 1'b1;
            end else begin
                stall_a = 1'b1;
            end
        end
    end

    assign req_ready_a_o = rst_ni && req_valid_a_i && !stall_a;
    assign req_ready_b_o = rst_ni && req_valid_b_i && !stall_b;
    assign acc_a = req_ready_a_o;
    assign acc_b = req_ready_b_o;

    always_comb begin
        state_n     = state;
        stall_cnt_n = stall_cnt;
        if (!req_valid_b_i || acc_b) begin
            stall_cnt_n = 4'd0;
        end else if (stall_cnt < STALL_LIM) begin
            stall_cnt_n = stall_cnt + 4'd1;
        end
        case (state)
            PRI_A: if (req_valid_b_i && !acc_b && stall_cnt_n >= STALL_LIM) state_n = PRI_B;
            PRI_B: if (acc_b) state_n = PRI_A;
            default: state_n = PRI_A;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= PRI_A;
            stall_cnt <= 4'd0;
        end else begin
            state     <= state_n;
            stall_cnt <= stall_cnt_n;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ram_en_a_o   <= 1'b0;
            ram_we_a_o   <= 1'b0;
            ram_addr_a_o <= '0;
            ram_data_a_o <= '0;
            ram_en_b_o   <= 1'b0;
            ram_we_b_o   <= 1'b0;
            ram_addr_b_o <= '0;
            ram_data_b_o <= '0;
        end else begin
            ram_en_a_o <= acc_a;
            ram_we_a_o <= acc_a && req_we_a_i;
            if (acc_a)               ram_addr_a_o <= req_addr_a_i;
            if (acc_a && req_we_a_i) ram_data_a_o <= req_wdata_a_i;
            ram_en_b_o <= acc_b;
            ram_we_b_o <= acc_b && req_we_b_i;
            if (acc_b)               ram_addr_b_o <= req_addr_b_i;
            if (acc_b && req_we_b_i) ram_data_b_o <= req_wdata_b_i;
        end
    end

    // Read return: strobe to RAM, RAM output one cycle later, then captured here.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_pend_a    <= 1'b0;
            rd_pend_b    <= 1'b0;
            rd_valid_a_o <= 1'b0;
            rd_valid_b_o <= 1'b0;
            rd_data_a_o  <= '0;
            rd_data_b_o  <= '0;
        end else begin
            rd_pend_a    <= ram_en_a_o && !ram_we_a_o;
            rd_pend_b    <= ram_en_b_o && !ram_we_b_o;
            rd_valid_a_o <= rd_pend_a;
            rd_valid_b_o <= rd_pend_b;
            if (rd_pend_a) rd_data_a_o <= ram_rdata_a_i;
            if (rd_pend_b) rd_data_b_o <= ram_rdata_b_i;
        end
    end

`ifdef DUAL_PORT_COLLISION_CNT_EN
    logic [7:0] coll_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            coll_cnt <= 8'd0;
        end else if (collision && coll_cnt != 8'hFF) begin
            coll_cnt <= coll_cnt + 8'd1;
        end
    end

    assign collision_cnt_o = coll_cnt;
`else
    assign collision_cnt_o = 8'd0;
`endif

endmodule
